// File: rtl/uart_word_tx_arbiter.sv
// uart_word_tx_arbiter: round-robin two-requester word serializer feeding a byte UART
module uart_word_tx_arbiter #(
  parameter bit         TERM_EN = 1'b1,
  parameter logic [7:0] TERM0   = 8'h0D,
  parameter logic [7:0] TERM1   = 8'h0A,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [31:0]      req_word0,
  input  logic [31:0]      req_word1,
  output logic [1:0]       req_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             busy,
  output logic             last_grant,
  output logic [CNT_W-1:0] words_sent
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [2:0] LAST = TERM_EN ? 3'd5 : 3'd3;
  state_t      state;
  logic [31:0] word;
  logic [2:0]  idx;
  logic        gnt;
  logic [31:0] gnt_word;
  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [2:0] i);
    return i == 3'd0 ? w[31:24] : i == 3'd1 ? w[23:16] : i == 3'd2 ? w[15:8] :
           i == 3'd3 ? w[7:0] : i == 3'd4 ? TERM0 : TERM1;
  endfunction
  // grant the sole valid requester, or the one not granted last time on contention
  always_comb begin
    gnt       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    gnt_word  = gnt ? req_word1 : req_word0;
    req_ready = (state == IDLE && rst_n) ?
                ((req_valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req_valid) : 2'b00;
  end
  // capture granted word, then present bytes one handshake at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      idx        <= '0;
      last_grant <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      words_sent <= '0;
    end else if (state == IDLE) begin
      if (|req_ready) begin
        state      <= SEND;
        word       <= gnt_word;
        idx        <= 3'd0;
        last_grant <= gnt;
        tx_valid   <= 1'b1;
        tx_data    <= gnt_word[31:24];
        busy       <= 1'b1;
      end
    end else if (tx_ready) begin
      if (idx == LAST) begin
        state      <= IDLE;
        tx_valid   <= 1'b0;
        tx_data    <= 8'h00;
        busy       <= 1'b0;
        words_sent <= words_sent + CNT_W'(1);
      end else begin
        idx     <= idx + 3'd1;
        tx_data <= byte_at(word, idx + 3'd1);
      end
    end
  end
endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// tb_uart_word_tx_arbiter: scoreboard bench for both terminator modes and counter wrap
module tb_uart_word_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  a_rv = 2'b00, b_rv = 2'b00;
  logic [31:0] a_w0 = '0, a_w1 = '0, b_w0 = '0, b_w1 = '0;
  logic [1:0]  a_rr, b_rr;
  logic        a_tv, b_tv, a_busy, b_busy, a_lg, b_lg;
  logic [7:0]  a_td, b_td;
  logic        a_trdy = 1'b1, b_trdy = 1'b1;
  logic [15:0] a_ws;
  logic [1:0]  b_ws;
  int          total = 0, bad = 0;
  logic [7:0]  qa[$], qb[$];

  uart_word_tx_arbiter #(.TERM_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_rv), .req_word0(a_w0), .req_word1(a_w1),
    .req_ready(a_rr), .tx_valid(a_tv), .tx_data(a_td), .tx_ready(a_trdy),
    .busy(a_busy), .last_grant(a_lg), .words_sent(a_ws));

  uart_word_tx_arbiter #(.TERM_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_rv), .req_word0(b_w0), .req_word1(b_w1),
    .req_ready(b_rr), .tx_valid(b_tv), .tx_data(b_td), .tx_ready(b_trdy),
    .busy(b_busy), .last_grant(b_lg), .words_sent(b_ws));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input bit b, input logic [31:0] w, input bit term);
    for (int i = 3; i >= 0; i--) begin
      if (b) qb.push_back(w[i*8 +: 8]);
      else qa.push_back(w[i*8 +: 8]);
    end
    if (term) begin
      qa.push_back(8'h0D);
      qa.push_back(8'h0A);
    end
  endtask

  task automatic wait_a_idle();
    int n = 0;
    while (a_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_idle_timeout", 32'(n >= 50), 0);
  endtask

  // scoreboard monitors: every byte handshake pops and compares
  always @(negedge clk) begin
    if (rst_n && a_tv && a_trdy) begin
      if (qa.size() == 0) chk("a_extra_byte", a_td, 32'hFFFF_FFFF);
      else chk("a_byte", a_td, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_tv && b_trdy) begin
      if (qb.size() == 0) chk("b_extra_byte", b_td, 32'hFFFF_FFFF);
      else chk("b_byte", b_td, qb.pop_front());
    end
  end

  initial begin
    int nb, n;
    logic [1:0] exp_ws [5];
    exp_ws = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    a_rv = 2'b11;
    #12;
    chk("rst_tx_valid", a_tv, 0);
    chk("rst_tx_data", a_td, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_words", a_ws, 0);
    chk("rst_last_grant", a_lg, 1);
    chk("rst_req_ready", a_rr, 0);
    a_rv = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // single word with terminator
    push_word(0, 32'h4142_4344, 1);
    @(posedge clk); #1;
    a_rv = 2'b01;
    a_w0 = 32'h4142_4344;
    @(negedge clk);
    chk("t1_ready", a_rr, 2'b01);
    chk("t1_busy_pre", a_busy, 0);
    @(posedge clk); #1;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_busy) nb++;
      if (i == 0) chk("t1_ready_send", a_rr, 2'b00);
      @(posedge clk); #1;
      if (i == 0) a_rv = 2'b00;
    end
    @(negedge clk);
    chk("t1_busy_cycles", nb, 6);
    chk("t1_busy_post", a_busy, 0);
    chk("t1_tx_valid_post", a_tv, 0);
    chk("t1_words", a_ws, 1);
    chk("t1_last_grant", a_lg, 0);
    // contention from reset: grants 0,1,0,1
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_word(0, 32'h1111_1111, 1);
    push_word(0, 32'h2222_2222, 1);
    push_word(0, 32'h1111_1111, 1);
    push_word(0, 32'h2222_2222, 1);
    a_w0 = 32'h1111_1111;
    a_w1 = 32'h2222_2222;
    a_rv = 2'b11;
    n = 0;
    while (a_ws != 16'd4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    a_rv = 2'b00;
    chk("t2_cycles", n, 28);
    chk("t2_words", a_ws, 4);
    chk("t2_last_grant", a_lg, 1);
    // backpressure on byte index 2
    push_word(0, 32'hDEAD_BEEF, 1);
    @(posedge clk); #1;
    a_rv = 2'b01;
    a_w0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    a_rv = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_trdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", a_tv, 1);
      chk("t3_hold_data", a_td, 8'hBE);
      @(posedge clk); #1;
    end
    a_trdy = 1'b1;
    wait_a_idle();
    chk("t3_words", a_ws, 5);
    // async reset mid-word
    push_word(0, 32'hCAFE_F00D, 0);
    qa.pop_back();
    qa.pop_back();
    @(posedge clk); #1;
    a_rv = 2'b01;
    a_w0 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    a_rv = 2'b00;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    a_rv = 2'b10;
    a_w1 = 32'h1234_5678;
    #1;
    chk("t4_rst_tx_valid", a_tv, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_words", a_ws, 0);
    chk("t4_rst_ready", a_rr, 0);
    chk("t4_q_drained", qa.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_word(0, 32'h1234_5678, 1);
    @(negedge clk);
    chk("t4_ready1", a_rr, 2'b10);
    @(posedge clk); #1;
    a_rv = 2'b00;
    wait_a_idle();
    chk("t4_words", a_ws, 1);
    chk("t4_last_grant", a_lg, 1);
    chk("a_q_empty", qa.size(), 0);
    // no terminator, 5-cycle word period, 2-bit counter wrap
    for (int k = 0; k < 5; k++) push_word(1, 32'h0102_0304, 0);
    @(posedge clk); #1;
    b_rv = 2'b01;
    b_w0 = 32'h0102_0304;
    for (int k = 0; k < 5; k++) begin
      repeat (5) @(posedge clk);
      #1;
      chk("t5_words", b_ws, exp_ws[k]);
      chk("t5_idle", b_busy, 0);
      chk("t5_regrant", b_rr, 2'b01);
    end
    b_rv = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_tx_valid_end", b_tv, 0);
    chk("b_q_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
